demux_sel_seq: RTL and testbench



---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_sel_seq_dwell_cnt.sv | 33 +++
 rtl/demux_sel_seq.sv | 134 +++++++++++++
 tb/tb_demux_sel_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg: definitions shared by the demux select sequencer.
//   state_t      - sequencer states (IDLE, DRIVE, GAP, FIN)
//   MODE_SCAN    - walk every channel 0..N-1
//   MODE_SINGLE  - drive only the directed channel
//   SEL_W_DEF / DWELL_W_DEF - default select and dwell widths
package demux_pkg;

    localparam int unsigned SEL_W_DEF   = 2;
    localparam int unsigned DWELL_W_DEF = 8;

    localparam logic MODE_SCAN   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/demux_sel_seq_dwell_cnt.sv
// dwell_cnt: loadable down-counter with a terminal-count flag.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset (clears the count)
//   load       - load load_val (takes priority over dec)
//   load_val   - value to load, expected >= 1
//   dec        - decrement by one
//   tc         - high while the count equals 1 (last cycle of a dwell)
module dwell_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == W'(1));

endmodule

// File: rtl/demux_sel_seq.sv
// demux_sel_seq: select/enable sequencer feeding a 1-to-(2**SEL_W) demux.
// On start it enables each channel for dwell cycles (0 treated as 1), with a
// one-cycle e=0 gap between channels. Scan mode walks 0..N-1, single mode
// drives ch_in only. abort in DRIVE/GAP ends the run through FIN (done pulse).
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   start      - request, accepted only in IDLE (mode/ch_in/dwell captured)
//   mode       - MODE_SCAN or MODE_SINGLE
//   ch_in      - channel for single mode
//   dwell      - enable-high cycles per channel
//   abort      - terminate the running sequence
//   a, e       - registered demux select and enable
//   busy       - high while the sequence runs (low in the FIN cycle)
//   done       - one-cycle completion pulse
// Build option: DEMUX_SEQ_LOOP_EN makes scan mode wrap to channel 0 forever,
// leaving abort as the only way to finish a scan.
module demux_sel_seq
    import demux_pkg::*;
#(
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic [SEL_W-1:0]   ch_in,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abort,
    output logic [SEL_W-1:0]   a,
    output logic               e,
    output logic               busy,
    output logic               done
);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   a_nxt;
    logic               mode_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_eff;
    logic               cap;
    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_val;
    logic               cnt_dec;
    logic               tc;
    logic               last_ch;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

`ifdef DEMUX_SEQ_LOOP_EN
    assign last_ch = (mode_r == MODE_SINGLE);
`else
    assign last_ch = (mode_r == MODE_SINGLE) || (a == '1);
`endif

    dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .tc       (tc)
    );

    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        cap       = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = dwell_r;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    cap       = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = dwell_eff;
                    a_nxt     = (mode == MODE_SINGLE) ? ch_in : '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_nxt = FIN;
                end else if (tc) begin
                    state_nxt = last_ch ? FIN : GAP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt = FIN;
                end else begin
                    // select advances only here, while e is already low
                    state_nxt = DRIVE;
                    a_nxt     = a + SEL_W'(1);
                    cnt_load  = 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // outputs are registered from the next state so they change on the edge
    // that enters the state they describe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a       <= '0;
            e       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mode_r  <= MODE_SCAN;
            dwell_r <= '0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            e     <= (state_nxt == DRIVE);
            busy  <= (state_nxt == DRIVE) || (state_nxt == GAP);
            done  <= (state_nxt == FIN);
            if (cap) begin
                mode_r  <= mode;
                dwell_r <= dwell_eff;
            end
        end
    end

endmodule

// File: tb/tb_demux_sel_seq.sv
module tb_demux_sel_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [1:0] ch_in;
    logic [7:0] dwell;
    logic       abort;
    logic [1:0] a;
    logic       e;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

`ifdef DEMUX_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    always #5 clk = ~clk;

    demux_sel_seq #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .ch_in (ch_in),
        .dwell (dwell),
        .abort (abort),
        .a     (a),
        .e     (e),
        .busy  (busy),
        .done  (done)
    );

    // expected per-cycle {a, e, busy, done} after start acceptance
    logic [4:0] exp_q[$];

    typedef struct {
        logic       m;
        logic [1:0] c;
        logic [7:0] d;
        int         ab;       // cycle index to assert abort in, -1 = none
        bit         poke;     // extra start pulse while busy
        bit         ab_start; // abort together with start
        int         exp_len;  // cycles from first e=1 through done
        int         exp_e;    // total e=1 cycles
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference trace from the sequencing rules: dwell cycles per channel,
    // a gap between channels, cut short after the abort cycle, then FIN.
    task automatic build(input logic m, input logic [1:0] c, input logic [7:0] d, input int ab);
        int dd;
        int chn;
        logic [1:0] la;
        exp_q.delete();
        dd  = (d == 0) ? 1 : int'(d);
        chn = m ? int'(c) : 0;
        while (exp_q.size() < 3000) begin
            for (int k = 0; k < dd; k++) exp_q.push_back({chn[1:0], 3'b110});
            if (m == 1'b1) break;
            if (!LOOP && chn == 3) break;
            if (ab >= 0 && exp_q.size() > ab) break;
            exp_q.push_back({chn[1:0], 3'b010});
            chn = (chn + 1) % 4;
        end
        if (ab >= 0 && exp_q.size() > ab)
            while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
        la = exp_q[exp_q.size()-1][4:3];
        exp_q.push_back({la, 3'b001});
    endtask

    task automatic run_txn(input logic m, input logic [1:0] c, input logic [7:0] d,
                           input int ab, input bit poke, input bit ab_start,
                           output int len_seen, output int e_seen);
        logic [4:0] got;
        logic [1:0] la;
        build(m, c, d, ab);
        la = exp_q[exp_q.size()-1][4:3];
        len_seen = -1;
        e_seen   = 0;
        @(negedge clk);
        start = 1'b1; mode = m; ch_in = c; dwell = d; abort = ab_start;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        // captured values must not follow later input changes
        mode = 1'($urandom); ch_in = 2'($urandom); dwell = 8'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            got = {a, e, busy, done};
            chk("trace", 32'(got), 32'(exp_q[i]));
            if (e) e_seen++;
            if (done && len_seen < 0) len_seen = i + 1;
            chk("e_done_excl", 32'(e & done), 32'd0);
            start = poke && (i == 1);
            abort = (i == ab);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_after", 32'({a, e, busy, done}), 32'({la, 3'b000}));
    endtask

    initial begin
        int ls, es, ab, dd, nat;
        logic m;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; ch_in = 2'd0; dwell = 8'd0; abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_idle", 32'({a, e, busy, done}), 32'd0);
        rst_n = 1'b1;

        // abort in IDLE is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({a, e, busy, done}), 32'd0);

        //            m     c     d      ab  poke st  len  e
        vecs[0] = '{1'b1, 2'd2, 8'd3,   -1, 0, 0,   4,  3};
        vecs[2] = '{1'b1, 2'd1, 8'd0,   -1, 0, 0,   2,  1};
        vecs[3] = '{1'b0, 2'd0, 8'd4,    6, 1, 0,   8,  6};
        vecs[4] = '{1'b1, 2'd0, 8'd255, -1, 0, 0, 256, 255};
        vecs[5] = '{1'b1, 2'd3, 8'd2,   -1, 0, 1,   3,  2};
        if (LOOP) begin
            vecs[1] = '{1'b0, 2'd0, 8'd2, 13, 0, 0, 15, 10};
            vecs[6] = '{1'b0, 2'd0, 8'd1, 11, 0, 0, 13,  6};
        end else begin
            vecs[1] = '{1'b0, 2'd0, 8'd2, -1, 0, 0, 12,  8};
            vecs[6] = '{1'b0, 2'd0, 8'd1, -1, 0, 0,  8,  4};
        end

        foreach (vecs[i]) begin
            run_txn(vecs[i].m, vecs[i].c, vecs[i].d, vecs[i].ab,
                    vecs[i].poke, vecs[i].ab_start, ls, es);
            chk($sformatf("vec%0d_len", i), 32'(ls), 32'(vecs[i].exp_len));
            chk($sformatf("vec%0d_ecnt", i), 32'(es), 32'(vecs[i].exp_e));
        end

        // reset in the middle of DRIVE: e drops, no done afterwards
        @(negedge clk);
        start = 1'b1; mode = 1'b1; ch_in = 2'd3; dwell = 8'd5;
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_e", 32'({a, e, busy}), 32'({2'd3, 2'b11}));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset", 32'({a, e, busy, done}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_quiet", 32'({a, e, busy, done}), 32'd0);
        end

        // randomized transactions against the reference trace
        for (int t = 0; t < 40; t++) begin
            m   = 1'($urandom);
            dd  = $urandom_range(0, 5);
            nat = m ? ((dd == 0) ? 1 : dd) : 4 * ((dd == 0) ? 1 : dd) + 3;
            if (LOOP && !m)
                ab = $urandom_range(0, 3 * nat);
            else if ($urandom_range(0, 1) == 0)
                ab = -1;
            else
                ab = $urandom_range(0, nat + 1);
            run_txn(m, 2'($urandom), 8'(dd), ab, 1'($urandom), 1'b0, ls, es);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
